// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the multiplier dispatcher slice.
//   W_DEFAULT - default operand width
//   state_e   - dispatcher FSM state encoding (IDLE=0, ISSUE=1, ARM=2, WAIT=3)
package mult_pkg;

    localparam int unsigned W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ARM   = 2'd2,
        WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/mult_dispatch_if.sv
// mult_dispatch_if: operand, multiplier and result handshake bundle.
//   in_valid/in_ready/in_a/in_b          operand stream into the dispatcher
//   mult_load/mult_a/mult_b              issue side to the shift-add multiplier
//   mult_p/mult_valid                    product returned by the multiplier
//   out_valid/out_ready/out_p            result stream out of the dispatcher
//   busy                                 dispatcher FSM not idle
// Modports: slave = dispatcher view, master = surrounding environment view.
interface mult_dispatch_if
    import mult_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) ();

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;

    logic           mult_load;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic [2*W-1:0] mult_p;
    logic           mult_valid;

    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    logic           busy;

    modport slave (
        input  in_valid, in_a, in_b, mult_p, mult_valid, out_ready,
        output in_ready, mult_load, mult_a, mult_b, out_valid, out_p, busy
    );

    modport master (
        output in_valid, in_a, in_b, mult_p, mult_valid, out_ready,
        input  in_ready, mult_load, mult_a, mult_b, out_valid, out_p, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered occupancy count.
//   clk, rst  clock, asynchronous active-high reset (empties the FIFO)
//   push/din  write request and data; ignored while full
//   pop       read request; ignored while empty
//   full      count == DEPTH
//   empty     count == 0
//   head      oldest entry (valid while !empty)
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mult_dispatch.sv
// mult_dispatch: queues operand pairs and feeds them one at a time to an
// external shift-add multiplier, holding each product until accepted.
//   clk, rst   clock, asynchronous active-high reset
//   bus        mult_dispatch_if.slave (operand in, multiplier, result out, busy)
//   op_count   16-bit wrapping count of captured results; present only when
//              MULT_DISPATCH_CNT_EN is defined
// FSM: IDLE -> ISSUE (load pulse, pop) -> ARM (ignore stale mult_valid)
//      -> WAIT (capture product) -> IDLE. No issue while a result is pending.
module mult_dispatch
    import mult_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef MULT_DISPATCH_CNT_EN
    mult_dispatch_if.slave bus,
    output logic [15:0]   op_count
`else
    mult_dispatch_if.slave bus
`endif
);

    localparam int unsigned PW = 2 * W;

    state_e        state_q;
    logic          mult_load_q;
    logic [W-1:0]  mult_a_q;
    logic [W-1:0]  mult_b_q;
    logic          out_valid_q;
    logic [PW-1:0] out_p_q;
    logic          busy_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [PW-1:0] fifo_head;
    logic          capture;

    sync_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .din   ({bus.in_a, bus.in_b}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign fifo_pop = (state_q == ISSUE);
    assign capture  = (state_q == WAIT) && bus.mult_valid;

    assign bus.in_ready  = !fifo_full;
    assign bus.mult_load = mult_load_q;
    assign bus.mult_a    = mult_a_q;
    assign bus.mult_b    = mult_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.busy      = busy_q;

    // Issue-side outputs are registered: they are loaded on the IDLE->ISSUE
    // edge from the FIFO head, which is exactly the entry popped in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mult_load_q <= 1'b0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty && !out_valid_q) begin
                        state_q     <= ISSUE;
                        mult_load_q <= 1'b1;
                        mult_a_q    <= fifo_head[PW-1:W];
                        mult_b_q    <= fifo_head[W-1:0];
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q     <= ARM;
                    mult_load_q <= 1'b0;
                    mult_a_q    <= '0;
                    mult_b_q    <= '0;
                end
                ARM: begin
                    // mult_valid still reflects the previous product here.
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.mult_valid) begin
                        out_p_q     <= bus.mult_p;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef MULT_DISPATCH_CNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_q <= '0;
        end else if (capture) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_mult_dispatch.sv
`timescale 1ns/1ps
module tb_mult_dispatch;
    import mult_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mult_dispatch_if #(.W(W)) bus ();

`ifdef MULT_DISPATCH_CNT_EN
    logic [15:0] op_count;
    int unsigned ops_base = 0;
`endif

    mult_dispatch #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MULT_DISPATCH_CNT_EN
        , .op_count (op_count)
`endif
    );

    // Environment multiplier: not reset, keeps reporting the previous product
    // as valid through the cycle after the load, then LAT cycles of work.
    logic          m_valid = 1'b1;
    logic [PW-1:0] m_p     = 8'hA5;
    logic [PW-1:0] m_prod  = '0;
    int unsigned   m_cnt   = 0;

    always @(posedge clk) begin
        if (bus.mult_load) begin
            m_prod <= PW'(bus.mult_a) * PW'(bus.mult_b);
            m_cnt  <= LAT;
        end else if (m_cnt > 1) begin
            m_valid <= 1'b0;
            m_cnt   <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_valid <= 1'b1;
            m_p     <= m_prod;
            m_cnt   <= 0;
        end
    end

    assign bus.mult_valid = m_valid;
    assign bus.mult_p     = m_p;

    logic ready_drv = 1'b1;
    logic rnd_en    = 1'b0;
    logic rnd_ready = 1'b1;
    assign bus.out_ready = rnd_en ? rnd_ready : ready_drv;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard state
    logic [PW-1:0]  resq[$];
    logic [2*W-1:0] opq[$];
    int          checks    = 0;
    int          failures  = 0;
    int unsigned load_cnt  = 0;
    int unsigned ov_cnt    = 0;
    int unsigned ops_done  = 0;
    logic [PW-1:0] last_p  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected_event required=none", name);
    endtask

    // Monitor: compares issued operands and accepted results against queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mult_load) begin
                load_cnt++;
                if (opq.size() == 0) fail_msg("mult_operands_unexpected");
                else check("mult_operands", 32'({bus.mult_a, bus.mult_b}), 32'(opq.pop_front()));
            end else begin
                check("mult_ab_idle_zero", 32'({bus.mult_a, bus.mult_b}), 32'd0);
            end
            if (bus.out_valid) begin
                ov_cnt++;
                if (bus.out_ready) begin
                    if (resq.size() == 0) fail_msg("result_unexpected");
                    else check("result", 32'(bus.out_p), 32'(resq.pop_front()));
                    last_p = bus.out_p;
                    ops_done++;
                end
            end
        end
    end

    // Drivers: called and return at posedge+1; push_pair leaves in_valid high.
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                opq.push_back({a, b});
                resq.push_back(PW'(a) * PW'(b));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail_msg("push_timeout");
    endtask

    task automatic drain();
        bit ok = 1'b0;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (resq.size() == 0 && opq.size() == 0 && !bus.busy && !bus.out_valid) ok = 1'b1;
        end
        check("drain_complete", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load();
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            seen = bus.mult_load;
        end
        check("load_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        resq.delete();
        opq.delete();
`ifdef MULT_DISPATCH_CNT_EN
        ops_base = ops_done;
`endif
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_p",     32'(bus.out_p),     32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_mult_load", 32'(bus.mult_load), 32'd0);
`ifdef MULT_DISPATCH_CNT_EN
        check("rst_op_count",  32'(op_count),      32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int unsigned l0;
        int unsigned v0;
        bit seen;
        logic [PW-1:0] p0;

        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        do_reset();

        // Single operation, result accepted immediately
        ready_drv = 1'b1;
        l0 = load_cnt;
        v0 = ov_cnt;
        push_pair(4'd3, 4'd5);
        drain();
        check("single_load_pulses",  l0 == load_cnt ? 32'd0 : load_cnt - l0, 32'd1);
        check("single_valid_cycles", ov_cnt - v0, 32'd1);
        check("single_p",            32'(last_p), 32'h0F);

        // Largest operands
        push_pair(4'd15, 4'd15);
        drain();
        check("max_p", 32'(last_p), 32'hE1);

        // Ordering of back-to-back operations
        push_pair(4'd2, 4'd7);
        push_pair(4'd4, 4'd4);
        push_pair(4'd1, 4'd9);
        drain();
        check("order_last_p", 32'(last_p), 32'h09);

        // Backpressure: result held, FIFO fills, no further issue
        ready_drv = 1'b0;
        l0 = load_cnt;
        push_pair(4'd1, 4'd2);
        push_pair(4'd3, 4'd4);
        push_pair(4'd5, 4'd6);
        push_pair(4'd7, 4'd8);
        push_pair(4'd9, 4'd10);
        check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_a = 4'd11;
        bus.in_b = 4'd11;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        check("bp_first_valid", 32'(seen), 32'd1);
        p0 = bus.out_p;
        check("bp_first_p", 32'(p0), 32'h02);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("bp_hold_valid",   32'(bus.out_valid), 32'd1);
            check("bp_hold_p",       32'(bus.out_p),     32'(p0));
            check("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
        end
        check("bp_single_load", load_cnt - l0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_drv    = 1'b1;
        drain();

        // Randomized operands, gaps and result backpressure
        rnd_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            push_pair(W'($urandom), W'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 6)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rnd_en = 1'b0;
        drain();

        // Reset while waiting on the multiplier, with a second pair queued
        push_pair(4'd9, 4'd3);
        push_pair(4'd5, 4'd5);
        bus.in_valid = 1'b0;
        wait_load();
        @(posedge clk);
        #1;
        check("midrst_busy_before",      32'(bus.busy),      32'd1);
        check("midrst_out_valid_before", 32'(bus.out_valid), 32'd0);
`ifdef MULT_DISPATCH_CNT_EN
        check("op_count_before_rst", 32'(op_count), 32'(16'(ops_done - ops_base)));
`endif
        do_reset();
        push_pair(4'd6, 4'd2);
        drain();
        check("after_rst_p", 32'(last_p), 32'h0C);

        push_pair(4'd2, 4'd3);
        push_pair(4'd4, 4'd5);
        drain();
`ifdef MULT_DISPATCH_CNT_EN
        check("op_count_three", 32'(op_count), 32'd3);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_dispatch.md
MULT_DISPATCH -- requirements
Module: mult_dispatch

Interface
REQ-001 Parameter W SHALL default to 4 and sets the operand width.
REQ-002 Parameter DEPTH SHALL default to 4 and sets the operand FIFO depth; it must be a power of 2 and at least 2.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock. All state changes on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 Operand input ports SHALL be: in_valid input 1; in_ready output 1; in_a input W; in_b input W.
REQ-006 Multiplier-side ports SHALL be: mult_load output 1; mult_a output W; mult_b output W; mult_p input 2W; mult_valid input 1. These connect to the downstream shift-add multiplier.
REQ-007 Result ports SHALL be: out_valid output 1; out_ready input 1; out_p output 2W.
REQ-008 Port busy SHALL be an output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-009 An operand pair SHALL be pushed into the FIFO when in_valid and in_ready are both high.
REQ-010 in_ready SHALL equal !full. A push attempted while full is ignored, even if a pop occurs in the same cycle.
REQ-011 The FIFO count register SHALL be clog2(DEPTH)+1 bits. Read and write pointers wrap modulo DEPTH.
REQ-012 The FSM SHALL have four states: IDLE, ISSUE, ARM, WAIT.
REQ-013 IDLE SHALL go to ISSUE when the FIFO is non-empty and out_valid is 0; otherwise it stays in IDLE.
REQ-014 ISSUE SHALL last exactly 1 cycle, with the following actions:
- mult_load = 1.
- mult_a and mult_b = FIFO head.
- The FIFO head is popped.
- Next state is ARM.
REQ-015 ARM SHALL last exactly 1 cycle and ignore mult_valid, because the multiplier still reports valid during the load cycle; next state is WAIT.
REQ-016 WAIT SHALL remain until mult_valid = 1. In that cycle, out_p <= mult_p, out_valid <= 1, and the next state is IDLE.
REQ-017 out_valid SHALL clear on the cycle where out_valid and out_ready are both high. out_p SHALL hold its value while out_valid = 1 and out_ready = 0.
REQ-018 mult_load SHALL be 0 in every state except ISSUE. mult_a and mult_b SHALL be 0 outside ISSUE.
REQ-019 A push and an ISSUE pop in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-020 Throughput SHALL be at most one operation per (multiplier latency + 3) cycles. No new issue occurs while a result is pending.

Reset
REQ-021 Asserting rst SHALL immediately force the following, regardless of clk:
- state = IDLE; FIFO empty, pointers 0;
- out_valid = 0, out_p = 0;
- mult_load = 0, busy = 0;
- in_ready = 1.
REQ-022 Reset mid-operation SHALL discard the in-flight operation and all queued operands. The next ISSUE restarts the multiplier via mult_load, since the multiplier is not reset.

Configuration
REQ-023 With macro MULT_DISPATCH_CNT_EN defined, the block SHALL add an output op_count (16 bits) that is reset to 0 and increments by 1 on each result capture in WAIT, wrapping from 0xFFFF to 0.
REQ-024 Without MULT_DISPATCH_CNT_EN, the op_count port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-025 The shared package mult_pkg SHALL hold the FSM state encoding (IDLE=0, ISSUE=1, ARM=2, WAIT=3) and the default W constant.
REQ-026 The FIFO SHALL be a sub-module named sync_fifo, parameterised by width (2W) and DEPTH, with push/pop/full/empty/head ports.

Verification
REQ-027 With W=4, push a=3, b=5, out_ready=1: the bench SHALL check that mult_load pulses once, then out_p=8'h0F with out_valid for 1 cycle.
REQ-028 With W=4, push a=15, b=15: the bench SHALL check that out_p=8'hE1.
REQ-029 Hold out_ready=0 and push 5 pairs back-to-back: the bench SHALL check that in_ready drops after the FIFO holds 4 entries, the 1st result holds steady, and no second mult_load occurs until out_ready=1.
REQ-030 Push (2,7),(4,4),(1,9) with out_ready=1: the bench SHALL check that results arrive in order 8'h0E, 8'h10, 8'h09.
REQ-031 Assert rst during WAIT: the bench SHALL check that out_valid=0, in_ready=1, and busy=0 immediately; then push (6,2) and check out_p=8'h0C.
REQ-032 With MULT_DISPATCH_CNT_EN defined, complete 3 operations: the bench SHALL check that op_count=3, and that op_count=0 after rst.
